// File: rtl/demux_1x4_reg_if.sv
// Producer/consumer bundle for the registered 1-to-4 demux.
// master drives the word and the consumer READY bits; slave is the demux.
interface demux_1x4_reg_if #(
   parameter int W  = 4,
   parameter int CW = 8
);
   logic [W-1:0]  X;
   logic [1:0]    S;
   logic          X_VALID;
   logic          X_READY;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic [W-1:0]  C;
   logic [W-1:0]  D;
   logic [3:0]    VALID;
   logic [3:0]    READY;
   logic [CW-1:0] CNT;

   modport master (
      output X, S, X_VALID, READY,
      input  X_READY, A, B, C, D, VALID, CNT
   );

   modport slave (
      input  X, S, X_VALID, READY,
      output X_READY, A, B, C, D, VALID, CNT
   );
endinterface

// File: rtl/demux_1x4_reg.sv
// Registered 1-to-4 demux: steers X to channel S into a one-entry holding register per channel.
// One cycle latency; a stalled channel only blocks words addressed to it.
module demux_1x4_reg #(
   parameter int W  = 4,
   parameter int CW = 8
) (
   input logic            clk,
   input logic            rst_n,
   demux_1x4_reg_if.slave bus
);
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } ch_state_t;

   ch_state_t     state      [4];
   ch_state_t     state_next [4];
   logic [W-1:0]  dat        [4];
   logic [CW-1:0] cnt;
   logic [3:0]    full;
   logic [3:0]    load;
   logic [3:0]    drain;
   logic          accept;

   always_comb begin
      full = '0;
      for (int k = 0; k < 4; k++) begin
         full[k] = (state[k] == FULL);
      end
   end

   // Readiness looks only at the addressed channel, so other stalls never leak in.
   assign bus.X_READY = rst_n & (~full[bus.S] | bus.READY[bus.S]);
   assign accept      = bus.X_VALID & bus.X_READY;

   always_comb begin
      load  = '0;
      drain = '0;
      for (int k = 0; k < 4; k++) begin
         load[k]  = accept & (bus.S == 2'(k));
         drain[k] = full[k] & bus.READY[k];
      end
   end

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         state_next[k] = state[k];
         case (state[k])
            EMPTY:   if (load[k]) state_next[k] = FULL;
            FULL:    if (drain[k] && !load[k]) state_next[k] = EMPTY;
            default: state_next[k] = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin
            state[k] <= EMPTY;
            dat[k]   <= '0;
         end
         cnt <= '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            state[k] <= state_next[k];
            // Data is kept after a drain; only a new load replaces it.
            if (load[k]) dat[k] <= bus.X;
         end
         if (accept) cnt <= cnt + CW'(1);
      end
   end

   assign bus.A     = dat[0];
   assign bus.B     = dat[1];
   assign bus.C     = dat[2];
   assign bus.D     = dat[3];
   assign bus.VALID = full;
   assign bus.CNT   = cnt;
endmodule

// File: tb/tb_demux_1x4_reg.sv
// Bench for demux_1x4_reg: directed scenarios plus random traffic against a per-channel slot model.
module tb_demux_1x4_reg;
   localparam int W  = 4;
   localparam int CW = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   demux_1x4_reg_if #(.W(W), .CW(CW)) bus ();
   demux_1x4_reg #(.W(W), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int total = 0;
   int bad   = 0;

   // Model: each channel is a slot that is either holding a word or not.
   bit           m_vld [4];
   logic [W-1:0] m_dat [4];
   int           m_cnt;
   logic [W-1:0] recv  [4][$];
   logic         last_xrdy;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] chan_out(input int k);
      case (k)
         0:       return bus.A;
         1:       return bus.B;
         2:       return bus.C;
         default: return bus.D;
      endcase
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         m_vld[k] = 1'b0;
         m_dat[k] = '0;
      end
      m_cnt = 0;
   endtask

   task automatic compare_outputs();
      logic [3:0] v;
      bit         exp_rdy;
      for (int k = 0; k < 4; k++) v[k] = m_vld[k];
      exp_rdy = !m_vld[bus.S] || bus.READY[bus.S];
      check("A", bus.A, m_dat[0]);
      check("B", bus.B, m_dat[1]);
      check("C", bus.C, m_dat[2]);
      check("D", bus.D, m_dat[3]);
      check("VALID", bus.VALID, v);
      check("CNT", bus.CNT, m_cnt % (1 << CW));
      check("X_READY", bus.X_READY, exp_rdy);
   endtask

   // One clock cycle of traffic: drive at negedge, compare, then advance the model for the coming edge.
   task automatic step(input logic [W-1:0] x, input logic [1:0] s, input bit xv, input logic [3:0] rdy);
      bit acc;
      @(negedge clk);
      bus.X       = x;
      bus.S       = s;
      bus.X_VALID = xv;
      bus.READY   = rdy;
      #1;
      compare_outputs();
      last_xrdy = bus.X_READY;
      for (int k = 0; k < 4; k++)
         if (bus.VALID[k] && rdy[k]) recv[k].push_back(chan_out(k));
      acc = xv && (!m_vld[s] || rdy[s]);
      for (int k = 0; k < 4; k++) begin
         if (acc && int'(s) == k) begin
            m_vld[k] = 1'b1;
            m_dat[k] = x;
         end else if (m_vld[k] && rdy[k]) begin
            m_vld[k] = 1'b0;
         end
      end
      if (acc) m_cnt++;
   endtask

   // Let the last stepped edge settle with an idle bus, for literal checks.
   task automatic peek();
      @(negedge clk);
      bus.X_VALID = 1'b0;
      bus.READY   = 4'b0000;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.X_VALID = 1'b0;
      bus.READY   = 4'b0000;
      rst_n       = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bus.X       = '0;
      bus.S       = 2'b00;
      bus.X_VALID = 1'b0;
      bus.READY   = 4'b0000;
      model_reset();

      // Power-on reset
      repeat (2) @(negedge clk);
      #1;
      check("rst_VALID", bus.VALID, 4'b0000);
      check("rst_CNT", bus.CNT, 0);
      check("rst_XRDY", bus.X_READY, 1'b0);
      rst_n = 1'b1;
      step(4'h0, 2'b00, 1'b0, 4'b0000);
      check("idle_XRDY", last_xrdy, 1'b1);

      // Steering with all consumers stalled
      step(4'h0, 2'b00, 1'b1, 4'b0000);
      step(4'h9, 2'b01, 1'b1, 4'b0000);
      step(4'h3, 2'b10, 1'b1, 4'b0000);
      step(4'h8, 2'b11, 1'b1, 4'b0000);
      peek();
      check("steer_A", bus.A, 4'h0);
      check("steer_B", bus.B, 4'h9);
      check("steer_C", bus.C, 4'h3);
      check("steer_D", bus.D, 4'h8);
      check("steer_VALID", bus.VALID, 4'b1111);
      check("steer_CNT", bus.CNT, 4);

      // Backpressure isolation: drain B, then a stalled A must not block B
      step(4'h0, 2'b01, 1'b0, 4'b0010);
      step(4'h5, 2'b00, 1'b1, 4'b0000);
      check("bp_XRDY_A", last_xrdy, 1'b0);
      step(4'h5, 2'b01, 1'b1, 4'b0000);
      check("bp_XRDY_B", last_xrdy, 1'b1);
      peek();
      check("bp_A", bus.A, 4'h0);
      check("bp_B", bus.B, 4'h5);
      check("bp_CNT", bus.CNT, 5);

      // Same-cycle drain and load into A
      step(4'h9, 2'b00, 1'b1, 4'b0001);
      step(4'h3, 2'b00, 1'b1, 4'b0001);
      check("dl_XRDY", last_xrdy, 1'b1);
      peek();
      check("dl_A", bus.A, 4'h3);
      check("dl_VALID", bus.VALID, 4'b1111);
      check("dl_CNT", bus.CNT, 7);

      // Asynchronous reset with VALID=0101
      do_reset();
      step(4'h5, 2'b00, 1'b1, 4'b0000);
      step(4'h6, 2'b10, 1'b1, 4'b0000);
      peek();
      check("pre_VALID", bus.VALID, 4'b0101);
      bus.S       = 2'b01;
      bus.X_VALID = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("arst_A", bus.A, 4'h0);
      check("arst_C", bus.C, 4'h0);
      check("arst_VALID", bus.VALID, 4'b0000);
      check("arst_CNT", bus.CNT, 0);
      check("arst_XRDY", bus.X_READY, 1'b0);
      @(negedge clk);
      bus.X_VALID = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(4'h0, 2'b00, 1'b0, 4'b0000);
      check("rel_XRDY", last_xrdy, 1'b1);
      peek();
      check("rel_VALID", bus.VALID, 4'b0000);
      check("rel_CNT", bus.CNT, 0);

      // Streaming 16 words, all consumers ready
      for (int k = 0; k < 4; k++) recv[k].delete();
      for (int i = 0; i < 16; i++) begin
         step(W'(i), 2'(i % 4), 1'b1, 4'b1111);
         check("stream_XRDY", last_xrdy, 1'b1);
      end
      step(4'h0, 2'b00, 1'b0, 4'b1111);
      peek();
      check("stream_CNT", bus.CNT, 16);
      for (int k = 0; k < 4; k++) begin
         check("stream_nrecv", recv[k].size(), 4);
         for (int j = 0; j < recv[k].size() && j < 4; j++)
            check("stream_order", recv[k][j], k + 4 * j);
      end

      // Counter wrap after 256 accepts
      do_reset();
      for (int i = 0; i < 256; i++)
         step(W'($urandom), 2'($urandom_range(0, 3)), 1'b1, 4'b1111);
      peek();
      check("wrap_CNT", bus.CNT, 0);

      // Random traffic
      for (int i = 0; i < 3000; i++)
         step(W'($urandom), 2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7), 4'($urandom));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/demux_1x4_reg.md
Name: demux_1x4_reg

Overview:
- Registered 1-to-4 demultiplexer: the inverse of the 4x1 MUX.
- Steers one input word X to one of four output channels A/B/C/D, chosen by S.
- Each channel has a one-entry holding register and a valid/ready handshake, so a stalled consumer never blocks the other channels.
- Sits between a single producer and four independent consumers in the lab datapath.

Parameters:
- W, 4, data width of X and of A/B/C/D.
- CW, 8, width of the accepted-word counter CNT.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- X  in  W  input data word.
- S  in  2  destination select: 00=A, 01=B, 10=C, 11=D.
- X_VALID  in  1  producer has a word on X/S.
- X_READY  out  1  block can accept X this cycle.
- A  out  W  channel 0 data (holding register).
- B  out  W  channel 1 data.
- C  out  W  channel 2 data.
- D  out  W  channel 3 data.
- VALID  out  4  per-channel valid; bit0=A, bit1=B, bit2=C, bit3=D.
- READY  in  4  per-channel consumer ready, same bit order.
- CNT  out  CW  total words accepted, modulo 2^CW.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - A=B=C=D=0, VALID=4'b0000, CNT=0.
  - X_READY forced 0 while rst_n is low.
  - Reset mid-transfer discards all held words; no partial state survives.
- Per-channel state machine, k in 0..3, two states:
  - EMPTY (VALID[k]=0), FULL (VALID[k]=1).
  - EMPTY -> FULL on load_k.
  - FULL -> EMPTY on drain_k & !load_k.
  - FULL -> FULL on load_k, whether or not drain_k; on load the data register takes the new X.
- Definitions:
  - drain_k = VALID[k] & READY[k].
  - load_k = accept & (S==k).
  - accept = X_VALID & X_READY.
- X_READY (combinational, rst_n high): X_READY = !VALID[S] | READY[S]. Ready depends only on the selected channel's state.
- Latency and throughput:
  - Word accepted at edge n appears on its channel with VALID high after edge n.
  - Sustained 1 word/cycle into any channel whose READY stays high, including back-to-back into the same channel (drain and load in the same cycle).
- Unselected channels are never modified by an accept; each drains independently on its own READY.
- Data registers are not cleared on drain; they hold the last loaded value while VALID is low.
- Consumer side: the data on channel k is stable while VALID[k]=1 and READY[k]=0.
- Producer obligations (not checked by the block):
  - Hold X and S stable while X_VALID=1 and X_READY=0.
  - Changing S while stalled is legal but redirects the pending word.
- CNT increments by 1 on every accept; it wraps from 2^CW-1 to 0 with no flag.
- X_VALID=0 has no effect on state; READY bits for EMPTY channels are ignored.

Test Plan:
- Reset/idle: assert rst_n=0 mid-run with VALID=4'b0101 -> A..D=0, VALID=0, CNT=0, X_READY=0 immediately; after release with X_VALID=0 -> X_READY=1, no state change.
- Steering (READY=4'b0000):
  - Send X=0000 S=00, X=1001 S=01, X=0011 S=10, X=1000 S=11 on consecutive cycles.
  - Required: A=0000 B=1001 C=0011 D=1000, VALID=4'b1111, CNT=4.
  - Each VALID bit rises one cycle after its accept.
- Backpressure isolation:
  - With A FULL and READY[0]=0, present S=00 -> X_READY=0, A unchanged.
  - Switch S=01 (B EMPTY) -> X_READY=1 and the word lands in B.
- Same-cycle drain+load: A FULL with 1001, READY[0]=1, X=0011 S=00 X_VALID=1 -> X_READY=1, A=0011 next cycle, VALID[0] stays 1, CNT+1.
- Streaming: READY=4'b1111, X_VALID=1 for 16 cycles, S cycling 00..11, X=0..15 -> every cycle accepted, each channel receives its words in order with no drops or duplicates, CNT=16.
- Counter wrap: 256 accepts with CW=8 -> CNT returns to 0, data path unaffected.
